// File: rtl/mem_arbiter_if.sv
// Request/grant bus for the two memory requesters plus the shared single-port memory bus.
// The arbiter uses the slave modport; requesters and memory sit on the master side.
interface mem_arbiter_if #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [AWIDTH-1:0] cpu_addr;
    logic [DWIDTH-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DWIDTH-1:0] cpu_rdata;
    logic              cpu_halted;

    logic              ext_req;
    logic              ext_we;
    logic [AWIDTH-1:0] ext_addr;
    logic [DWIDTH-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DWIDTH-1:0] ext_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_halted,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_halted,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous memory between the CPU and the loader.
// One-cycle grants; read data returns to the owning port the cycle after mem_rd.
module mem_arbiter #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_,
    mem_arbiter_if.slave  io_bus
);
    typedef enum logic [1:0] {StIdle, StGCpu, StGExt} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_last_ext;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [AWIDTH-1:0] r_mem_addr;
    logic [DWIDTH-1:0] r_mem_wdata;
    logic              r_rd_pending;
    logic              r_rd_tag;      // read owner: 1 = loader
    logic [DWIDTH-1:0] r_cpu_rdata;
    logic [DWIDTH-1:0] r_ext_rdata;

    logic w_cpu_elig;
    logic w_ext_elig;
    logic w_cpu_gnt;
    logic w_ext_gnt;
    logic w_cpu_rvalid;
    logic w_ext_rvalid;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A port in its own grant cycle sits out, so alternating ports can go back-to-back.
    always_comb begin
        w_cpu_elig   = io_bus.cpu_req & ~io_bus.cpu_halted & ~w_cpu_gnt;
        w_ext_elig   = io_bus.ext_req & ~w_ext_gnt;
        w_state_next = StIdle;
        if (w_cpu_elig && w_ext_elig) begin
            w_state_next = r_last_ext ? StGCpu : StGExt;
        end else if (w_cpu_elig) begin
            w_state_next = StGCpu;
        end else if (w_ext_elig) begin
            w_state_next = StGExt;
        end
    end

    always_comb begin
        w_cpu_gnt    = (r_state == StGCpu);
        w_ext_gnt    = (r_state == StGExt);
        w_cpu_rvalid = r_rd_pending & ~r_rd_tag;
        w_ext_rvalid = r_rd_pending & r_rd_tag;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_last_ext   <= 1'b1;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rd_pending <= 1'b0;
            r_rd_tag     <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ext_rdata  <= '0;
        end else begin
            r_rd_pending <= r_mem_rd;
            r_rd_tag     <= w_ext_gnt;
            if (w_cpu_rvalid) begin
                r_cpu_rdata <= io_bus.mem_rdata;
            end
            if (w_ext_rvalid) begin
                r_ext_rdata <= io_bus.mem_rdata;
            end
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            unique case (w_state_next)
                StGCpu: begin
                    r_last_ext  <= 1'b0;
                    r_mem_addr  <= io_bus.cpu_addr;
                    r_mem_wdata <= io_bus.cpu_wdata;
                    r_mem_wr    <= io_bus.cpu_we;
                    r_mem_rd    <= ~io_bus.cpu_we;
                end
                StGExt: begin
                    r_last_ext  <= 1'b1;
                    r_mem_addr  <= io_bus.ext_addr;
                    r_mem_wdata <= io_bus.ext_wdata;
                    r_mem_wr    <= io_bus.ext_we;
                    r_mem_rd    <= ~io_bus.ext_we;
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.cpu_gnt    = w_cpu_gnt;
    assign io_bus.ext_gnt    = w_ext_gnt;
    assign io_bus.cpu_rvalid = w_cpu_rvalid;
    assign io_bus.ext_rvalid = w_ext_rvalid;
    // Returned data is passed straight through in the rvalid cycle, then held.
    assign io_bus.cpu_rdata  = w_cpu_rvalid ? io_bus.mem_rdata : r_cpu_rdata;
    assign io_bus.ext_rdata  = w_ext_rvalid ? io_bus.mem_rdata : r_ext_rdata;
    assign io_bus.mem_rd     = r_mem_rd;
    assign io_bus.mem_wr     = r_mem_wr;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_wdata  = r_mem_wdata;
    assign io_bus.busy       = r_mem_rd | r_mem_wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model with its own memory image.
module tb_mem_arbiter;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk    (clk),
        .rst_   (rst_),
        .io_bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? 8'h3C : 8'((a * 37) + 11);
    endfunction

    // Synchronous memory device on the arbiter's memory bus.
    logic [DW-1:0] ram [32];
    bit            ram_wr [32];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (bus.mem_wr) begin
            ram[bus.mem_addr]    <= bus.mem_wdata;
            ram_wr[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_rd) begin
            ram_q <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_val(int'(bus.mem_addr));
        end
    end
    assign bus.mem_rdata = ram_q;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: who owns the memory each cycle and what each read returns.
    logic          m_cpu_gnt, m_ext_gnt, m_rd, m_wr, m_last_ext;
    logic          m_cpu_rv, m_ext_rv;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_cpu_rdata, m_ext_rdata;
    logic [DW-1:0] m_mem [32];
    bit            m_written [32];

    task automatic model_reset();
        m_cpu_gnt = 0; m_ext_gnt = 0; m_rd = 0; m_wr = 0; m_last_ext = 1;
        m_cpu_rv = 0; m_ext_rv = 0; m_addr = '0; m_wdata = '0;
        m_cpu_rdata = '0; m_ext_rdata = '0;
    endtask

    task automatic model_step();
        bit cpu_ok, ext_ok;
        int win;  // 0 none, 1 cpu, 2 ext
        logic [DW-1:0] rd_val;
        cpu_ok = bus.cpu_req && !bus.cpu_halted && !m_cpu_gnt;
        ext_ok = bus.ext_req && !m_ext_gnt;
        if (cpu_ok && ext_ok) win = m_last_ext ? 1 : 2;
        else if (cpu_ok)      win = 1;
        else if (ext_ok)      win = 2;
        else                  win = 0;
        rd_val   = m_written[m_addr] ? m_mem[m_addr] : init_val(int'(m_addr));
        m_cpu_rv = m_rd && m_cpu_gnt;
        m_ext_rv = m_rd && m_ext_gnt;
        if (m_cpu_rv) m_cpu_rdata = rd_val;
        if (m_ext_rv) m_ext_rdata = rd_val;
        if (m_wr) begin
            m_mem[m_addr]     = m_wdata;
            m_written[m_addr] = 1'b1;
        end
        m_cpu_gnt = (win == 1);
        m_ext_gnt = (win == 2);
        m_rd = 0;
        m_wr = 0;
        if (win == 1) begin
            m_last_ext = 0; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
            m_wr = bus.cpu_we; m_rd = !bus.cpu_we;
        end else if (win == 2) begin
            m_last_ext = 1; m_addr = bus.ext_addr; m_wdata = bus.ext_wdata;
            m_wr = bus.ext_we; m_rd = !bus.ext_we;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_);
            if (!rst_) model_reset();
            else       model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cmp("cyc_grant", 64'({bus.cpu_gnt, bus.ext_gnt, bus.mem_rd, bus.mem_wr, bus.busy}),
                64'({m_cpu_gnt, m_ext_gnt, m_rd, m_wr, m_rd | m_wr}));
            cmp("cyc_rvalid", 64'({bus.cpu_rvalid, bus.ext_rvalid}), 64'({m_cpu_rv, m_ext_rv}));
            cmp("cyc_rdata", 64'({bus.cpu_rdata, bus.ext_rdata}), 64'({m_cpu_rdata, m_ext_rdata}));
            cmp("cyc_membus", 64'({bus.mem_addr, bus.mem_wdata}), 64'({m_addr, m_wdata}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_rdata, bus.ext_gnt, bus.ext_rvalid,
                    bus.ext_rdata, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.busy});
    endfunction

    initial begin
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
        bus.cpu_halted = 0;
        repeat (2) @(posedge clk);
        #2;
        cmp("reset_outputs", all_outs(), 64'd0);
        rst_ = 1'b1;

        // CPU read of address 5
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'd5;
        tick();
        cmp("t1_gnt_strobes", 64'({bus.cpu_gnt, bus.ext_gnt, bus.mem_rd, bus.mem_wr}), 64'b1010);
        cmp("t1_addr", 64'(bus.mem_addr), 64'd5);
        bus.cpu_req = 0;
        tick();
        cmp("t1_rvalid", 64'({bus.cpu_rvalid, bus.ext_rvalid}), 64'b10);
        cmp("t1_rdata", 64'({bus.cpu_rdata, bus.ext_rdata}), 64'h3C00);

        // Loader write then read of address 31
        bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 5'd31; bus.ext_wdata = 8'hA5;
        tick();
        cmp("t2_wr_strobes", 64'({bus.ext_gnt, bus.mem_wr, bus.mem_rd}), 64'b110);
        cmp("t2_wr_bus", 64'({bus.mem_addr, bus.mem_wdata}), 64'({5'd31, 8'hA5}));
        bus.ext_we = 0; bus.ext_wdata = 8'h00;
        tick();
        cmp("t2_no_regrant", 64'({bus.ext_gnt, bus.busy}), 64'b00);
        tick();
        cmp("t2_rd_strobes", 64'({bus.ext_gnt, bus.mem_rd, bus.mem_wr}), 64'b110);
        bus.ext_req = 0;
        tick();
        cmp("t2_rvalid", 64'({bus.ext_rvalid, bus.cpu_rvalid}), 64'b10);
        cmp("t2_rdata", 64'({bus.ext_rdata, bus.cpu_rdata}), 64'hA53C);

        // Both requests held from reset: CPU first, then strict alternation
        rst_ = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'd5;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 5'd31;
        tick();
        rst_ = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp($sformatf("t3_gnt%0d", i), 64'({bus.cpu_gnt, bus.ext_gnt}),
                (i % 2 == 0) ? 64'b10 : 64'b01);
            cmp($sformatf("t3_rv%0d", i), 64'({bus.cpu_rvalid, bus.ext_rvalid}),
                (i == 0) ? 64'b00 : ((i % 2 == 1) ? 64'b10 : 64'b01));
        end
        cmp("t3_rdata", 64'({bus.cpu_rdata, bus.ext_rdata}), 64'h3CA5);

        // CPU halted: loader gets every slot it can use
        bus.cpu_req = 0; bus.ext_req = 0;
        tick();
        tick();
        bus.cpu_halted = 1; bus.cpu_req = 1; bus.ext_req = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            cmp($sformatf("t4_halt_gnt%0d", i), 64'({bus.cpu_gnt, bus.ext_gnt}),
                (i % 2 == 0) ? 64'b01 : 64'b00);
        end
        bus.cpu_halted = 0;
        tick();
        cmp("t4_unhalt_cpu_wins", 64'({bus.cpu_gnt, bus.ext_gnt, bus.mem_rd}), 64'b101);

        // Asynchronous reset between mem_rd and rvalid
        #1 rst_ = 0;
        #1;
        cmp("t5_async_clear", all_outs(), 64'd0);
        tick();
        cmp("t5_held_clear", all_outs(), 64'd0);
        rst_ = 1;
        tick();
        cmp("t5_post_reset_tie", 64'({bus.cpu_gnt, bus.ext_gnt}), 64'b10);
        cmp("t5_no_stale_rvalid", 64'({bus.cpu_rvalid, bus.ext_rvalid}), 64'b00);

        // CPU request abandoned while the loader wins
        bus.cpu_req = 0; bus.ext_req = 0;
        tick();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 5'd7; bus.cpu_wdata = 8'h77;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 5'd31;
        tick();
        cmp("t6_ext_wins", 64'({bus.cpu_gnt, bus.ext_gnt, bus.mem_addr}), 64'({2'b01, 5'd31}));
        bus.cpu_req = 0; bus.ext_req = 0;
        tick();
        cmp("t6_no_cpu_access", 64'({bus.cpu_gnt, bus.mem_rd, bus.mem_wr}), 64'b000);
        tick();
        cmp("t6_still_idle", 64'({bus.cpu_gnt, bus.ext_gnt, bus.busy}), 64'b000);

        // Random traffic obeying the requester rules
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (!rst_) rst_ = 1;
            if (bus.cpu_gnt || !bus.cpu_req) begin
                bus.cpu_req   = ($urandom_range(0, 99) < 45);
                bus.cpu_we    = 1'($urandom);
                bus.cpu_addr  = 5'($urandom);
                bus.cpu_wdata = 8'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                bus.cpu_req = 0;
            end
            if (bus.ext_gnt || !bus.ext_req) begin
                bus.ext_req   = ($urandom_range(0, 99) < 45);
                bus.ext_we    = 1'($urandom);
                bus.ext_addr  = 5'($urandom);
                bus.ext_wdata = 8'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                bus.ext_req = 0;
            end
            if ($urandom_range(0, 99) < 4) bus.cpu_halted = ~bus.cpu_halted;
            if ($urandom_range(0, 999) < 3) begin
                #1 rst_ = 0;
            end
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous program/data memory between two requesters.
- Port 0 is the CPU, driven by the sequence controller's memory strobes. Port 1 is the external loader/debug port used for program load and memory inspection.
- Arbitration is round-robin with a CPU-halt mask. The block drives the memory strobes, address and write data, and routes read data back with a per-port valid.

Parameters:
- AWIDTH, 5, memory address width (32 locations).
- DWIDTH, 8, memory data width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request; held until cpu_gnt
- cpu_we  input  1  1 = write, 0 = read; valid while cpu_req
- cpu_addr  input  AWIDTH  CPU address
- cpu_wdata  input  DWIDTH  CPU write data
- cpu_gnt  output  1  one-cycle grant pulse for CPU
- cpu_rvalid  output  1  CPU read data valid
- cpu_rdata  output  DWIDTH  CPU read data
- ext_req, ext_we, ext_addr, ext_wdata  input  1/1/AWIDTH/DWIDTH  loader port, same rules as CPU
- ext_gnt, ext_rvalid, ext_rdata  output  1/1/DWIDTH  loader port grant and read return
- cpu_halted  input  1  CPU halt flag; masks cpu_req while high
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- mem_addr  output  AWIDTH  memory address
- mem_wdata  output  DWIDTH  memory write data
- mem_rdata  input  DWIDTH  memory read data, valid the cycle after mem_rd
- busy  output  1  high in any cycle with mem_rd or mem_wr high

Behaviour:
- Reset: rst_ is asynchronous and active-low; clk is the clock. Asserting rst_ clears all outputs to 0, sets last_winner to EXT (so the CPU wins the first tie) and drops any pending rvalid. This applies at any time, including mid-transaction.
- Eligibility at each rising edge: cpu_eligible = cpu_req & ~cpu_halted & ~cpu_gnt. ext_eligible = ext_req & ~ext_gnt.
  - A port is not re-arbitrated in its own grant cycle. Each port is therefore limited to one access per 2 cycles; alternating ports can issue back-to-back.
- Arbitration and state machine:
  - States: IDLE (no grant), G_CPU, G_EXT. Each grant state lasts exactly one cycle.
  - From any state: only one port eligible -> that port's grant state. Both eligible -> the port that is not last_winner. Neither eligible -> IDLE.
  - last_winner updates on entry to G_CPU or G_EXT.
- Grant cycle (registered, one cycle after the deciding edge):
  - gnt of the winning port = 1.
  - mem_addr and mem_wdata are loaded from that port.
  - mem_wr = we; mem_rd = ~we.
  - mem_rd and mem_wr are never both high. Outside grant cycles both are 0, and mem_addr/mem_wdata hold their last values.
- Read return:
  - A 1-bit tag and rd_pending register capture the owner of each read.
  - In the cycle after mem_rd, the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rvalid = 0 and its rdata holds its last value.
  - Total read latency is 2 cycles from the deciding edge to rvalid. Writes produce no rvalid; gnt is the write acknowledgement.
- Requester rule: addr/we/wdata must stay stable from req rise until gnt. The requester may drop req, or present a new request, in the gnt cycle.
- cpu_halted rising while cpu_req is pending: the CPU request is masked and the loader gets every slot. An already-issued CPU grant or read return completes normally.
- req dropped before gnt: the request is not performed, and no grant is issued if it drops before the deciding edge.
- Address values wrap naturally within AWIDTH; no range check.
- busy = mem_rd | mem_wr.

Test Plan:
- Reset then single CPU read of addr 5 (mem[5]=8'h3C): cpu_gnt, mem_rd, mem_addr=5 one cycle after the req edge; cpu_rvalid=1, cpu_rdata=8'h3C the next cycle; ext outputs stay 0.
- Ext write addr 31 data 8'hA5, then ext read addr 31: mem_wr=1, mem_wdata=8'hA5 in the grant cycle; after the read, ext_rvalid=1, ext_rdata=8'hA5; mem_rd and mem_wr never both 1.
- Both req held continuously from reset: grants alternate CPU, EXT, CPU, EXT in consecutive cycles, with the CPU first; each rvalid is routed to the correct port with no cross-talk.
- cpu_halted=1 with both req high for 6 cycles: only ext_gnt pulses (every 2 cycles); cpu_gnt=0; deassert the halt and the CPU wins the next tie.
- rst_ low asserted asynchronously between mem_rd and rvalid: all outputs go to 0 immediately; no rvalid after release; the first post-reset tie goes to the CPU.
- CPU drops req one cycle after raising it, before any grant (ext winning meanwhile): no cpu_gnt and no CPU memory access occurs.
